bcd_pulse_counter: RTL
======================

# bcd_pulse_counter

Digit-serial BCD up/down counter driven by the single-cycle increment/decrement pulses from the pushbutton pulse FSMs. It sits between the button front-end (one pulse FSM per button) and the display/register logic. It turns press and auto-repeat pulses into a bounded decimal value, with overlap resolution, pending-event buffering and a change strobe for downstream consumers.

## Interface
- N_DIGITS, 4, number of BCD digits (≥1); value range 0 … 10^N_DIGITS−1
- clk  input  1  system clock, all logic on rising edge
- resetN  input  1  synchronous, active-low reset
- inc_pulse  input  1  increment request (from up-button pulse FSM)
- dec_pulse  input  1  decrement request (from down-button pulse FSM)
- clear  input  1  synchronous clear of the count, active-high
- count_bcd  output  4*N_DIGITS  current value, digit 0 in bits [3:0]
- busy  output  1  scan in progress; count_bcd may be mid-update
- changed  output  1  one-cycle strobe: count_bcd holds a new final value
- at_max  output  1  all digits = 9 (combinational from count_bcd)
- at_min  output  1  all digits = 0 (combinational from count_bcd)
- limit  output  1  one-cycle strobe: request rejected at a bound (saturate build only)
- overrun  output  1  one-cycle strobe: request dropped, pending slot already full

## Operation
- Edge detection: a request is a rising edge of inc_pulse/dec_pulse, relative to a registered copy of the previous sample. A level held for several cycles counts once.
- Same-cycle inc and dec edges cancel; no update, no strobe.
- FSM states:
  - IDLE: no scan in progress.
    - On a request, load the direction and digit index 0, then go to SCAN.
    - In the saturate build, an inc request with at_max=1 or a dec request with at_min=1 stays in IDLE and pulses limit.
  - SCAN: one digit per cycle, starting at index 0.
    - inc: digit 9→0 with carry; otherwise +1 and carry clears.
    - dec: digit 0→9 with borrow; otherwise −1 and borrow clears.
    - Leave SCAN when carry/borrow clears or the index reaches N_DIGITS−1. The final digit's carry/borrow is discarded, which gives the wrap-around.
    - On leaving SCAN, pulse changed. Then go to SCAN (index 0) if a pending request exists, otherwise to IDLE.
- Pending slots: one inc slot and one dec slot.
  - A request arriving while busy=1 sets its slot.
  - If both slots become set, both clear (net zero).
  - A request for a slot that is already set is dropped and pulses overrun.
- Bound check for pending requests: the saturate bound check is applied when a pending request is dequeued, against the value at that moment.
- clear has priority over everything:
  - zeros all digits, aborts any scan, empties both slots, goes to IDLE;
  - pulses changed in the following cycle;
  - drops request edges sampled in the same cycle.

## Timing
- Reset (resetN=0 at an edge): count_bcd=0, busy=0, changed=0, limit=0, overrun=0, FSM=IDLE, slots empty, edge registers=0. at_min=1 and at_max=0 follow combinationally.
- Edge k samples a request in IDLE → busy=1 from k.
- Each SCAN cycle writes one digit at the next edge.
- Latency from request edge to changed=1:
  - 1 cycle when no carry/borrow (e.g. 0004→0005);
  - up to N_DIGITS cycles worst case (0999→1000: 4 cycles).
- changed, limit and overrun are registered and high for exactly one cycle.
- busy falls in the same cycle that changed rises, unless a pending request is chained.
- Minimum request spacing without using a pending slot: N_DIGITS+1 cycles. This fits the button FSM auto-repeat period by a wide margin.
- Reset mid-scan: value returns to 0 and no strobe is generated.

## Configuration
- SATURATE_EN defined:
  - increments stop at 10^N_DIGITS−1 and decrements stop at 0;
  - rejected requests pulse limit and leave count_bcd and changed untouched.
- SATURATE_EN undefined:
  - the counter wraps (9999+1→0000, 0000−1→9999), so changed pulses on every accepted request;
  - limit is tied to 0.

## Test plan
- Reset, then one 1-cycle inc_pulse from 0000 → count_bcd=0001, changed high 1 cycle after the request edge, busy high 1 cycle.
- Preload 0999 via inc bursts, then one inc → 4 busy cycles, count_bcd=1000, single changed strobe.
- inc_pulse and dec_pulse rising on the same edge at 0500 → count stays 0500, no changed.
- At 0999, inc then a second inc 1 cycle later (during busy) → pending served, final 1001. A third inc while the slot is full → overrun pulse, final value still 1001.
- With SATURATE_EN at 9999, inc → limit pulse, value 9999. Without SATURATE_EN → 0000 after 4 cycles, changed pulses. Then dec from 0000 → 9999 without SATURATE_EN; with SATURATE_EN → limit pulse, value stays 0000.
- clear asserted during the second scan cycle of 0999→1000 → count 0000 the next cycle, busy=0, changed pulse; resetN=0 mid-scan → all outputs at reset values.

Source files
------------

// File: rtl/bcd_pulse_counter.sv
// bcd_pulse_counter: digit-serial BCD up/down counter fed by button pulses.
// Optional SATURATE_EN macro: clamp at 0 and max instead of wrapping.
module bcd_pulse_counter #(
  parameter int N_DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  logic                  inc_pulse,
  input  logic                  dec_pulse,
  input  logic                  clear,
  output logic [4*N_DIGITS-1:0] count_bcd,
  output logic                  busy,
  output logic                  changed,
  output logic                  at_max,
  output logic                  at_min,
  output logic                  limit,
  output logic                  overrun
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int W  = 4 * N_DIGITS;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t        state;
  logic          inc_q;
  logic          dec_q;
  logic          dir_up;
  logic          pend_inc;
  logic          pend_dec;
  logic [IW-1:0] idx;

  logic          inc_edge;
  logic          dec_edge;
  logic          inc_req;
  logic          dec_req;
  logic [3:0]    digit;
  logic [3:0]    digit_nx;
  logic          carry;
  logic          last;
  logic          leave;
  logic [W-1:0]  count_nx;
  logic          p_inc;
  logic          p_dec;
  logic          ovr;
  logic          req_block;
  logic          deq_block;

  assign busy     = (state == SCAN);
  assign inc_edge = inc_pulse & ~inc_q;
  assign dec_edge = dec_pulse & ~dec_q;
  assign inc_req  = inc_edge & ~dec_edge;
  assign dec_req  = dec_edge & ~inc_edge;

  always_comb begin
    at_max = 1'b1;
    at_min = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (count_bcd[4*i +: 4] != 4'd9) at_max = 1'b0;
      if (count_bcd[4*i +: 4] != 4'd0) at_min = 1'b0;
    end
  end

  // One digit per cycle; the last digit's carry/borrow falls off (wrap)
  always_comb begin
    digit = count_bcd[4*int'(idx) +: 4];
    if (dir_up) begin
      carry    = (digit == 4'd9);
      digit_nx = carry ? 4'd0 : digit + 4'd1;
    end else begin
      carry    = (digit == 4'd0);
      digit_nx = carry ? 4'd9 : digit - 4'd1;
    end
    last     = (int'(idx) == N_DIGITS - 1);
    leave    = !carry || last;
    count_nx = count_bcd;
    count_nx[4*int'(idx) +: 4] = digit_nx;
  end

  always_comb begin
    p_inc = pend_inc;
    p_dec = pend_dec;
    ovr   = 1'b0;
    if (inc_req) begin
      if (pend_inc) ovr = 1'b1;
      else          p_inc = 1'b1;
    end
    if (dec_req) begin
      if (pend_dec) ovr = 1'b1;
      else          p_dec = 1'b1;
    end
    if (p_inc && p_dec) begin
      p_inc = 1'b0;
      p_dec = 1'b0;
    end
  end

`ifdef SATURATE_EN
  logic nx_max;
  logic nx_min;

  always_comb begin
    nx_max = 1'b1;
    nx_min = 1'b1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (count_nx[4*i +: 4] != 4'd9) nx_max = 1'b0;
      if (count_nx[4*i +: 4] != 4'd0) nx_min = 1'b0;
    end
  end

  // Dequeued requests are bounded against the value just written
  always_comb begin
    req_block = (inc_req && at_max) || (dec_req && at_min);
    deq_block = (p_inc && nx_max) || (p_dec && nx_min);
  end
`else
  always_comb begin
    req_block = 1'b0;
    deq_block = 1'b0;
  end
`endif

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state     <= IDLE;
      count_bcd <= '0;
      inc_q     <= 1'b0;
      dec_q     <= 1'b0;
      dir_up    <= 1'b0;
      pend_inc  <= 1'b0;
      pend_dec  <= 1'b0;
      idx       <= '0;
      changed   <= 1'b0;
      limit     <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      inc_q   <= inc_pulse;
      dec_q   <= dec_pulse;
      changed <= 1'b0;
      limit   <= 1'b0;
      overrun <= 1'b0;
      if (clear) begin
        state     <= IDLE;
        count_bcd <= '0;
        pend_inc  <= 1'b0;
        pend_dec  <= 1'b0;
        idx       <= '0;
        changed   <= 1'b1;
      end else begin
        unique case (state)
          IDLE: begin
            if (inc_req || dec_req) begin
              if (req_block) begin
                limit <= 1'b1;
              end else begin
                state  <= SCAN;
                dir_up <= inc_req;
                idx    <= '0;
              end
            end
          end
          SCAN: begin
            count_bcd <= count_nx;
            overrun   <= ovr;
            if (leave) begin
              changed  <= 1'b1;
              pend_inc <= 1'b0;
              pend_dec <= 1'b0;
              idx      <= '0;
              if ((p_inc || p_dec) && !deq_block) begin
                dir_up <= p_inc;
              end else begin
                state <= IDLE;
                limit <= deq_block;
              end
            end else begin
              idx      <= idx + 1'b1;
              pend_inc <= p_inc;
              pend_dec <= p_dec;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
